img_fetch: RTL and testbench
============================

# img_fetch

Raster-order reader for the image ROM. On a `start` pulse it walks the full CH×WIN×WIN image, drives the ROM address port one word per cycle, absorbs the ROM's one-cycle registered read latency, and presents pixels on a valid/ready stream with channel/row/column tags. It sits between the image ROM and the first convolution layer's input buffer, and tolerates arbitrary backpressure without losing or duplicating pixels.

## Interface
- `WIDTH`, 16, pixel word width
- `CH`, 3, number of channels (planes)
- `ADDR`, 18, ROM address width; CH·WIN·WIN ≤ 2**ADDR
- `WIN`, 256, image height and width (square)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset: synchronous, active-high
- `start`  in  1  one-cycle pulse, begins a frame fetch; ignored while `busy`
- `rom_addr`  out  ADDR  address to ROM
- `rom_data`  in  WIDTH  ROM registered output (valid one edge after address is sampled)
- `pix_data`  out  WIDTH  pixel word
- `pix_valid`  out  1  pixel available
- `pix_ready`  in  1  consumer accepts; transfer when valid&ready
- `pix_ch`  out  clog2(CH)  channel of current pixel
- `pix_row`, `pix_col`  out  clog2(WIN)  coordinates of current pixel
- `pix_last`  out  1  high with the final pixel of the frame
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after final transfer

## Operation
- Address map: addr = ch·WIN·WIN + row·WIN + col; order col fastest, then row, then ch.
- States: IDLE → FETCH (issuing reads) → DRAIN (all reads issued, waiting for stream to empty) → IDLE.
- IDLE: `start` → FETCH, `busy`=1, issue counter = 0.
- Issue side: `rom_addr` is a register; an issue loads it with the next address and increments the issue counter. Issue allowed when state FETCH and occ + inflight < 4 (occ = FIFO occupancy, inflight = issued reads not yet captured, 0..2, both before this cycle's pop).
- Issue tag pipeline: 2-stage shift of issue bits; when tag exits stage 2, `rom_data` pushed into 4-deep FIFO.
- After issue of address CH·WIN·WIN−1 → DRAIN.
- Output side: `pix_valid` = FIFO non-empty; `pix_data` = FIFO head. Independent tag counters (ch,row,col) advance on each transfer, same order/wrap as addresses.
- `pix_last` = valid and tags at (CH−1, WIN−1, WIN−1).
- DRAIN: on last transfer → IDLE; `done`=1 next cycle, `busy`=0 same cycle as `done`.
- `start` in FETCH/DRAIN: ignored, no effect on counters.
- `rst` (any state, mid-frame included): state IDLE, FIFO and tag pipeline flushed, all counters 0; in-flight ROM data discarded.
- Reset values: `rom_addr`=0, `pix_valid`=0, `pix_data`=0, `pix_ch/row/col`=0, `pix_last`=0, `busy`=0, `done`=0.
- FIFO never overflows by construction of the credit rule; push and pop in same cycle keep occ constant.

## Timing
- `start` sampled at edge E0 → first `rom_addr`=0 after E0; ROM data after E1; pushed at E2; `pix_valid`=1 from cycle after E2 (3 cycles start→first valid).
- With `pix_ready` held 1: one pixel per cycle sustained, no bubbles after first valid; frame completes in CH·WIN·WIN+3 cycles from `start`, `done` one cycle after last transfer.
- Backpressure: `pix_data`/tags stable while valid & !ready. Issue stalls within one cycle once credit exhausted; at most 4 pixels buffered.
- Next `start` accepted in the cycle `done` is high.

## Test plan
- Free-run: ROM model with value = address, WIDTH=16, ready=1 → 196608 transfers, pix_data==expected address, first valid 3 cycles after start, `done` one cycle after `pix_last`.
- Random backpressure (ready 50% random) → identical in-order sequence, no drops/dupes, FIFO occ never >4, data stable while stalled.
- Tag check with small params (CH=2, WIN=4): pix_ch/row/col step (0,0,0)…(1,3,3), `pix_last` only on 32nd transfer.
- `start` pulsed during FETCH and DRAIN → ignored, sequence unchanged, single `done`.
- `rst` mid-frame after ~100 transfers with 4 buffered → next cycle all outputs 0; new `start` restarts from address 0, no stale data emitted.
- Ready held 0 for 20 cycles after start → exactly 4 reads issued, `rom_addr`=3 frozen, then full recovery on ready=1.

Source files
------------

// File: rtl/img_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : img_fetch
//  Description : Raster-order image ROM reader. Walks CH x WIN x WIN words,
//                absorbs the ROM's one-cycle read latency, and presents
//                pixels on a valid/ready stream with ch/row/col tags.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_fetch #(
    parameter int WIDTH = 16,
    parameter int CH    = 3,
    parameter int ADDR  = 18,
    parameter int WIN   = 256,
    localparam int CHW  = (CH  > 1) ? $clog2(CH)  : 1,
    localparam int RCW  = (WIN > 1) ? $clog2(WIN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [ADDR-1:0]  rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [CHW-1:0]   pix_ch,
    output logic [RCW-1:0]   pix_row,
    output logic [RCW-1:0]   pix_col,
    output logic             pix_last,
    output logic             busy,
    output logic             done
);

    localparam int              TOTAL     = CH * WIN * WIN;
    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(TOTAL - 1);
    localparam logic [CHW-1:0]  CH_MAX    = CHW'(CH - 1);
    localparam logic [RCW-1:0]  RC_MAX    = RCW'(WIN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [ADDR-1:0]  iss_q;        // next address to issue
    logic [ADDR-1:0]  rom_addr_q;
    logic             busy_q;
    logic             done_q;

    logic             tag1_q;       // read issued last cycle
    logic             tag2_q;       // ROM data for that read is on rom_data now

    logic [WIDTH-1:0] mem_q [4];
    logic [1:0]       wr_q;
    logic [1:0]       rd_q;
    logic [2:0]       occ_q;

    logic [CHW-1:0]   ch_q;
    logic [RCW-1:0]   row_q;
    logic [RCW-1:0]   col_q;

    logic [2:0]       credit_used;
    logic             kick;
    logic             issue;
    logic             launch;
    logic             push;
    logic             pop;
    logic             last_xfer;

    // Buffered plus in-flight words may never exceed the 4-entry FIFO, so
    // every issued read is guaranteed a slot when its data returns.
    assign credit_used = occ_q + {2'b00, tag1_q} + {2'b00, tag2_q};
    assign kick        = (state_q == S_IDLE) && start;
    assign issue       = (state_q == S_FETCH) && (credit_used < 3'd4);
    assign launch      = kick || issue;
    assign push        = tag2_q;
    assign pop         = pix_valid && pix_ready;
    assign last_xfer   = pop && pix_last;

    // Frame sequencer: address issue, busy/done and state transitions.
    // The start cycle itself issues address 0 so the first pixel appears
    // three cycles after start; the issue counter therefore resumes at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            iss_q      <= '0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rom_addr_q <= '0;
                        iss_q      <= ADDR'(1);
                        busy_q     <= 1'b1;
                        state_q    <= (LAST_ADDR == '0) ? S_DRAIN : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        rom_addr_q <= iss_q;
                        iss_q      <= iss_q + ADDR'(1);
                        if (iss_q == LAST_ADDR) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_xfer) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read-latency tag pipeline and 4-deep pixel FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_q   <= 2'd0;
            rd_q   <= 2'd0;
            occ_q  <= 3'd0;
            tag1_q <= 1'b0;
            tag2_q <= 1'b0;
        end else begin
            tag1_q <= launch;
            tag2_q <= tag1_q;
            if (push) begin
                mem_q[wr_q] <= rom_data;
                wr_q        <= wr_q + 2'd1;
            end
            if (pop) begin
                rd_q <= rd_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 3'd1;
                2'b01:   occ_q <= occ_q - 3'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Output coordinate tags, stepped once per accepted pixel in raster order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if (pop) begin
            if (col_q == RC_MAX) begin
                col_q <= '0;
                if (row_q == RC_MAX) begin
                    row_q <= '0;
                    ch_q  <= (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_valid = (occ_q != 3'd0);
    assign pix_data  = mem_q[rd_q];
    assign pix_ch    = ch_q;
    assign pix_row   = row_q;
    assign pix_col   = col_q;
    assign pix_last  = pix_valid && (ch_q == CH_MAX) && (row_q == RC_MAX)
                       && (col_q == RC_MAX);
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_img_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_fetch
//  Description : Directed self-checking bench for img_fetch (CH=2, WIN=4).
//                ROM model returns 16'hA000 | address one edge after the
//                address is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_img_fetch;

    localparam int WIDTH = 16;
    localparam int CH    = 2;
    localparam int ADDR  = 6;
    localparam int WIN   = 4;
    localparam int TOTAL = CH * WIN * WIN;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             pix_ready;
    logic [ADDR-1:0]  rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] pix_data;
    logic             pix_valid;
    logic [0:0]       pix_ch;
    logic [1:0]       pix_row;
    logic [1:0]       pix_col;
    logic             pix_last;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    img_fetch #(
        .WIDTH (WIDTH),
        .CH    (CH),
        .ADDR  (ADDR),
        .WIN   (WIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_ch    (pix_ch),
        .pix_row   (pix_row),
        .pix_col   (pix_col),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Registered-output ROM model
    always @(posedge clk) rom_data <= 16'hA000 | 16'(rom_addr);

    // Expected {valid, data, ch, row, col, last} for the k-th pixel
    function automatic logic [22:0] exp_vec(input int k);
        logic [15:0] d;
        logic [0:0]  c;
        logic [1:0]  r;
        logic [1:0]  cl;
        logic        l;
        d  = 16'hA000 | 16'(k);
        c  = 1'(k / (WIN * WIN));
        r  = 2'((k / WIN) % WIN);
        cl = 2'(k % WIN);
        l  = (k == TOTAL - 1);
        return {1'b1, d, c, r, cl, l};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
        step(); step();
        checks++;
        if ({rom_addr, pix_valid, pix_data, pix_ch, pix_row, pix_col, pix_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%h v=%b d=%h tags=%h/%h/%h last=%b busy=%b done=%b, expected all 0",
                     rom_addr, pix_valid, pix_data, pix_ch, pix_row, pix_col, pix_last, busy, done);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b done=%b, expected 0/0/0", busy, pix_valid, done);
        end
    endtask

    task automatic test_free_run();
        int cyc;
        logic [22:0] obs;
        pix_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rom_addr !== 6'd0) begin
            failures++;
            $display("FAIL fr_start: got busy=%b addr=%0d, expected busy=1 addr=0", busy, rom_addr);
        end
        cyc = 1;
        while (pix_valid !== 1'b1 && cyc < 10) begin step(); cyc++; end
        checks++;
        if (cyc !== 3) begin
            failures++;
            $display("FAIL fr_latency: got %0d cycles start->valid, expected 3", cyc);
        end
        for (int k = 0; k < TOTAL; k++) begin
            obs = {pix_valid, pix_data, pix_ch, pix_row, pix_col, pix_last};
            checks++;
            if (obs !== exp_vec(k)) begin
                failures++;
                $display("FAIL fr_pixel %0d: got %h, expected %h", k, obs, exp_vec(k));
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL fr_done: got done=%b busy=%b valid=%b, expected 1/0/0", done, busy, pix_valid);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL fr_done_pulse: got done=%b, expected 0", done);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        logic [22:0] obs;
        int k;
        pat = 16'b1011_0010_1110_0101;
        k = 0;
        pix_ready = 1'b0; start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 600 && k < TOTAL; c++) begin
            pix_ready = pat[c % 16];
            if (pix_valid === 1'b1) begin
                obs = {pix_valid, pix_data, pix_ch, pix_row, pix_col, pix_last};
                checks++;
                if (obs !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL bp_pixel %0d cyc %0d: got %h, expected %h", k, c, obs, exp_vec(k));
                end
                if (pix_ready) k++;
            end
            step();
        end
        pix_ready = 1'b0;
        checks++;
        if (k !== TOTAL || done !== 1'b1) begin
            failures++;
            $display("FAIL bp_complete: got %0d transfers done=%b, expected %0d done=1", k, done, TOTAL);
        end
        step();
    endtask

    task automatic test_start_ignored();
        logic [22:0] obs;
        int k;
        int dones;
        k = 0; dones = 0;
        pix_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 200 && k < TOTAL; c++) begin
            start = (k == 5 || k == TOTAL - 2) && (pix_valid === 1'b1);
            if (done === 1'b1) dones++;
            if (pix_valid === 1'b1) begin
                obs = {pix_valid, pix_data, pix_ch, pix_row, pix_col, pix_last};
                checks++;
                if (obs !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL si_pixel %0d: got %h, expected %h", k, obs, exp_vec(k));
                end
                k++;
            end
            step();
        end
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done === 1'b1) dones++;
            step();
        end
        checks++;
        if (k !== TOTAL || dones !== 1) begin
            failures++;
            $display("FAIL si_done_count: got %0d transfers %0d done pulses, expected %0d and 1", k, dones, TOTAL);
        end
    endtask

    task automatic test_stall();
        logic [ADDR-1:0] prev;
        logic [22:0] obs;
        int changes;
        int k;
        changes = 0; k = 0;
        pix_ready = 1'b0; start = 1'b1; step(); start = 1'b0;
        checks++;
        if (rom_addr !== 6'd0) begin
            failures++;
            $display("FAIL st_first_addr: got %0d, expected 0", rom_addr);
        end
        prev = rom_addr;
        repeat (20) begin
            step();
            if (rom_addr !== prev) changes++;
            prev = rom_addr;
        end
        checks++;
        if (changes + 1 !== 4) begin
            failures++;
            $display("FAIL st_issue_count: got %0d reads, expected 4", changes + 1);
        end
        checks++;
        if (rom_addr !== 6'd3) begin
            failures++;
            $display("FAIL st_addr: got %0d, expected 3", rom_addr);
        end
        checks++;
        if ({pix_valid, pix_data} !== {1'b1, 16'hA000}) begin
            failures++;
            $display("FAIL st_head: got v=%b d=%h, expected v=1 d=a000", pix_valid, pix_data);
        end
        pix_ready = 1'b1;
        for (int c = 0; c < 200 && k < TOTAL; c++) begin
            if (pix_valid === 1'b1) begin
                obs = {pix_valid, pix_data, pix_ch, pix_row, pix_col, pix_last};
                checks++;
                if (obs !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL st_pixel %0d: got %h, expected %h", k, obs, exp_vec(k));
                end
                k++;
            end
            step();
        end
        checks++;
        if (k !== TOTAL || done !== 1'b1) begin
            failures++;
            $display("FAIL st_complete: got %0d transfers done=%b, expected %0d done=1", k, done, TOTAL);
        end
        step();
    endtask

    task automatic test_mid_reset();
        logic [22:0] obs;
        int k;
        int cyc;
        k = 0;
        pix_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 100 && k < 20; c++) begin
            if (pix_valid === 1'b1) k++;
            step();
        end
        pix_ready = 1'b0;
        repeat (6) step();
        checks++;
        if ({pix_valid, pix_data} !== {1'b1, 16'hA000 | 16'd20}) begin
            failures++;
            $display("FAIL mr_buffered: got v=%b d=%h, expected v=1 d=%h", pix_valid, pix_data, 16'hA000 | 16'd20);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({rom_addr, pix_valid, pix_data, pix_ch, pix_row, pix_col, pix_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL mr_outputs: got addr=%h v=%b d=%h tags=%h/%h/%h last=%b busy=%b done=%b, expected all 0",
                     rom_addr, pix_valid, pix_data, pix_ch, pix_row, pix_col, pix_last, busy, done);
        end
        rst = 1'b0;
        pix_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mr_no_stale: got valid=%b busy=%b done=%b, expected 0/0/0", pix_valid, busy, done);
        end
        start = 1'b1; step(); start = 1'b0;
        cyc = 1;
        while (pix_valid !== 1'b1 && cyc < 10) begin step(); cyc++; end
        checks++;
        if (cyc !== 3) begin
            failures++;
            $display("FAIL mr_latency: got %0d cycles start->valid, expected 3", cyc);
        end
        for (int j = 0; j < TOTAL; j++) begin
            obs = {pix_valid, pix_data, pix_ch, pix_row, pix_col, pix_last};
            checks++;
            if (obs !== exp_vec(j)) begin
                failures++;
                $display("FAIL mr_pixel %0d: got %h, expected %h", j, obs, exp_vec(j));
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL mr_done: got done=%b, expected 1", done);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [22:0] obs;
        int cyc;
        pix_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 200 && done !== 1'b1; c++) step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL bb_first_done: got done=%b, expected 1", done);
        end
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rom_addr !== 6'd0) begin
            failures++;
            $display("FAIL bb_restart: got busy=%b addr=%0d, expected busy=1 addr=0", busy, rom_addr);
        end
        cyc = 1;
        while (pix_valid !== 1'b1 && cyc < 10) begin step(); cyc++; end
        checks++;
        if (cyc !== 3) begin
            failures++;
            $display("FAIL bb_latency: got %0d cycles start->valid, expected 3", cyc);
        end
        for (int k = 0; k < TOTAL; k++) begin
            obs = {pix_valid, pix_data, pix_ch, pix_row, pix_col, pix_last};
            checks++;
            if (obs !== exp_vec(k)) begin
                failures++;
                $display("FAIL bb_pixel %0d: got %h, expected %h", k, obs, exp_vec(k));
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bb_done: got done=%b busy=%b, expected 1/0", done, busy);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
        test_reset();
        test_free_run();
        test_backpressure();
        test_start_ignored();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
